// File: rtl/issue_queue_free_list.sv
// issue_queue_free_list
// Circular free list of issue-queue entry indices. Dispatch lanes take free
// entries from the head, and the wakeup pipeline's release lanes return
// entries at the tail. Grants are compacted over the requesting lanes, and
// releases are compacted over the asserted release lanes.
// Optional misuse checker: define RSD_ISSUE_QUEUE_FREE_LIST_CHECK_EN to build
// the isFree tracking vector and the sticky error flag. Without it, error is
// tied to 0.
module issue_queue_free_list #(
    parameter int ENTRY_NUM      = 16,
    parameter int INDEX_WIDTH    = 4,
    parameter int DISPATCH_WIDTH = 2,
    parameter int RELEASE_WIDTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   allocReq     [DISPATCH_WIDTH],
    output logic [INDEX_WIDTH-1:0] allocPtr     [DISPATCH_WIDTH],
    output logic                   allocatable,
    input  logic                   releaseEntry [RELEASE_WIDTH],
    input  logic [INDEX_WIDTH-1:0] releasePtr   [RELEASE_WIDTH],
    output logic [INDEX_WIDTH:0]   freeCount,
    output logic                   error
);

    // Wide enough to hold count + every release lane before saturation.
    localparam int SUM_WIDTH = $clog2(ENTRY_NUM + RELEASE_WIDTH + 1) + 1;

    typedef logic [INDEX_WIDTH-1:0] index_t;
    typedef logic [INDEX_WIDTH:0]   cnt_t;
    typedef logic [SUM_WIDTH-1:0]   sum_t;

    index_t mem [ENTRY_NUM];
    index_t head;
    index_t tail;
    cnt_t   count;

    sum_t   alloc_num;
    sum_t   alloc_eff;
    sum_t   release_num;
    sum_t   count_sum;
    cnt_t   count_next;
    index_t release_addr [RELEASE_WIDTH];

    assign allocatable = (count >= cnt_t'(DISPATCH_WIDTH));
    assign freeCount   = count;

    // Grant compaction: a requesting lane takes the slot after all lower
    // requesting lanes; an idle lane just previews the slot at its own offset.
    always_comb begin
        // NOTE: alloc_num is a running sum read within this same block, so it
        // needs blocking assignments and an explicit default before the loop;
        // every path then assigns it and no latch is inferred.
        alloc_num = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (allocReq[i]) begin
                allocPtr[i] = mem[head + index_t'(alloc_num)];
                alloc_num   = alloc_num + sum_t'(1);
            end else begin
                allocPtr[i] = mem[head + index_t'(i)];
            end
        end
    end

    // Release compaction: the k-th asserted release lane writes at tail + k.
    always_comb begin
        release_num = '0;
        for (int j = 0; j < RELEASE_WIDTH; j++) begin
            release_addr[j] = tail + index_t'(release_num);
            if (releaseEntry[j]) begin
                release_num = release_num + sum_t'(1);
            end
        end
    end

    // Next count: requests made while not allocatable consume nothing, and
    // releases past a full list saturate at ENTRY_NUM.
    always_comb begin
        alloc_eff = allocatable ? alloc_num : '0;
        count_sum = sum_t'(count) + release_num - alloc_eff;
        if (count_sum > sum_t'(ENTRY_NUM)) begin
            count_next = cnt_t'(ENTRY_NUM);
        end else begin
            count_next = cnt_t'(count_sum);
        end
    end

    // Pointer, count and index storage; the reset image lists every entry as
    // free in index order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= cnt_t'(ENTRY_NUM);
            // NOTE: the storage is reset on purpose. Its reset contents are
            // the initial free list, so leaving it unreset would hand out
            // garbage indices after power-up.
            for (int i = 0; i < ENTRY_NUM; i++) begin
                mem[i] <= index_t'(i);
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // the reads above always see pre-edge values.
            head  <= head + index_t'(alloc_eff);
            tail  <= tail + index_t'(release_num);
            count <= count_next;
            for (int j = 0; j < RELEASE_WIDTH; j++) begin
                if (releaseEntry[j]) begin
                    mem[release_addr[j]] <= releasePtr[j];
                end
            end
        end
    end

`ifdef RSD_ISSUE_QUEUE_FREE_LIST_CHECK_EN
    logic [ENTRY_NUM-1:0] isFree;
    logic [ENTRY_NUM-1:0] isFree_next;
    logic                 violation;
    logic                 error_q;

    // Track per-entry ownership and flag any protocol misuse this cycle.
    always_comb begin
        isFree_next = isFree;
        violation   = (count_sum > sum_t'(ENTRY_NUM));
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (allocReq[i]) begin
                if (allocatable) begin
                    isFree_next[allocPtr[i]] = 1'b0;
                end else begin
                    violation = 1'b1;
                end
            end
        end
        for (int j = 0; j < RELEASE_WIDTH; j++) begin
            if (releaseEntry[j]) begin
                if (isFree[releasePtr[j]]) begin
                    violation = 1'b1;
                end
                for (int k = j + 1; k < RELEASE_WIDTH; k++) begin
                    if (releaseEntry[k] && (releasePtr[k] == releasePtr[j])) begin
                        violation = 1'b1;
                    end
                end
                isFree_next[releasePtr[j]] = 1'b1;
            end
        end
    end

    // Sticky error flag and ownership vector; only rst clears the flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            isFree  <= '1;
            error_q <= 1'b0;
        end else begin
            isFree  <= isFree_next;
            error_q <= error_q | violation;
        end
    end

    assign error = error_q;

`ifndef SYNTHESIS
    // Report each offending cycle in simulation.
    always_ff @(posedge clk) begin
        if (!rst && violation) begin
            $error("issue_queue_free_list: free-list protocol violation");
        end
    end
`endif
`else
    assign error = 1'b0;
`endif

endmodule
